// File: rtl/reg_bank8_pkg.sv
// rtl/reg_bank8_pkg.sv - shared sizes and write-source decode for reg_bank8
package reg_bank8_pkg;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;
  localparam int WIDTH  = 16;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_CLEAR,
    WR_LOAD,
    WR_PUSH
  } wr_src_e;

  // clear beats load beats push; a losing request has no side effects
  function automatic wr_src_e decode_wr_src(input logic clear, input logic load, input logic push);
    if (clear) return WR_CLEAR;
    if (load)  return WR_LOAD;
    if (push)  return WR_PUSH;
    return WR_NONE;
  endfunction

endpackage

// File: rtl/reg_bank8_mux8way16.sv
// rtl/reg_bank8_mux8way16.sv - 8-way WIDTH-bit read mux (Mux8Way16)
module Mux8Way16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  input  logic [WIDTH-1:0] d4_i,
  input  logic [WIDTH-1:0] d5_i,
  input  logic [WIDTH-1:0] d6_i,
  input  logic [WIDTH-1:0] d7_i,
  input  logic [2:0]       sel_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    case (sel_i)
      3'd0:    y_o = d0_i;
      3'd1:    y_o = d1_i;
      3'd2:    y_o = d2_i;
      3'd3:    y_o = d3_i;
      3'd4:    y_o = d4_i;
      3'd5:    y_o = d5_i;
      3'd6:    y_o = d6_i;
      3'd7:    y_o = d7_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/reg_bank8.sv
// rtl/reg_bank8.sv - eight-register bank with direct/push writes and mux read
// Optional write-through forwarding on the read port under REG_BANK8_BYPASS_EN.
module reg_bank8 #(
  parameter int WIDTH = reg_bank8_pkg::WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             load,
  input  logic [reg_bank8_pkg::ADDR_W-1:0] wr_addr,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 in,
  input  logic [reg_bank8_pkg::ADDR_W-1:0] rd_sel,
  output logic [WIDTH-1:0]                 out,
  output logic [reg_bank8_pkg::ADDR_W-1:0] wptr,
  output logic [reg_bank8_pkg::CNT_W-1:0]  count,
  output logic                             full
);
  import reg_bank8_pkg::*;

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  wr_src_e           wr_src;
  logic [WIDTH-1:0]  mux_y;

  always_comb wr_src = decode_wr_src(clear, load, push);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    wptr_d  = wptr_q;
    count_d = count_q;
    case (wr_src)
      WR_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
        wptr_d  = '0;
        count_d = '0;
      end
      WR_LOAD: regs_d[wr_addr] = in;
      WR_PUSH: begin
        // a push into a full bank overwrites the oldest slot; count saturates
        regs_d[wptr_q] = in;
        wptr_d         = wptr_q + 1'b1;
        count_d        = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  Mux8Way16 #(.WIDTH(WIDTH)) u_rd_mux (
    .d0_i  (regs_q[0]),
    .d1_i  (regs_q[1]),
    .d2_i  (regs_q[2]),
    .d3_i  (regs_q[3]),
    .d4_i  (regs_q[4]),
    .d5_i  (regs_q[5]),
    .d6_i  (regs_q[6]),
    .d7_i  (regs_q[7]),
    .sel_i (rd_sel),
    .y_o   (mux_y)
  );

`ifdef REG_BANK8_BYPASS_EN
  logic fwd_hit;

  // nothing is accepted while reset is held, so nothing is forwarded either
  always_comb begin
    fwd_hit = rst_n && (((wr_src == WR_LOAD) && (wr_addr == rd_sel)) ||
                        ((wr_src == WR_PUSH) && (wptr_q == rd_sel)));
    if (rst_n && (wr_src == WR_CLEAR)) out = '0;
    else if (fwd_hit)                  out = in;
    else                               out = mux_y;
  end
`else
  assign out = mux_y;
`endif

  assign wptr  = wptr_q;
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_reg_bank8.sv
// tb/tb_reg_bank8.sv - randomized bench for reg_bank8 against a behavioural model
module tb_reg_bank8;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        load;
  logic [2:0]  wr_addr;
  logic        push;
  logic [15:0] din;
  logic [2:0]  rd_sel;
  logic [15:0] dout;
  logic [2:0]  wptr;
  logic [3:0]  count;
  logic        full;

  reg_bank8 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .load    (load),
    .wr_addr (wr_addr),
    .push    (push),
    .in      (din),
    .rd_sel  (rd_sel),
    .out     (dout),
    .wptr    (wptr),
    .count   (count),
    .full    (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: register contents plus total pushes since reset/clear
  logic [15:0] mem [8];
  int          pushes;
  int          vectors;
  int          miscompares;
  bit          chk_en;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    pushes = 0;
  endtask

  task automatic model_step();
    if (!rst_n || clear) model_reset();
    else if (load) mem[wr_addr] = din;
    else if (push) begin
      mem[pushes % 8] = din;
      pushes++;
    end
  endtask

  function automatic int exp_cnt();
    return (pushes > 8) ? 8 : pushes;
  endfunction

  function automatic logic [15:0] exp_out();
    if (!rst_n) return 16'h0;
`ifdef REG_BANK8_BYPASS_EN
    if (clear) return 16'h0;
    if (load && wr_addr == rd_sel) return din;
    if (!load && push && (pushes % 8) == int'(rd_sel)) return din;
`endif
    return mem[rd_sel];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out", {16'h0, dout}, {16'h0, exp_out()});
      chk("wptr", {29'h0, wptr}, pushes % 8);
      chk("count", {28'h0, count}, exp_cnt());
      chk("full", {31'h0, full}, {31'h0, exp_cnt() == 8});
    end
  end

  // called at posedge+1; applies controls for one edge, returns at posedge+1
  task automatic apply(input logic c, input logic l, input logic [2:0] a, input logic p,
                       input logic [15:0] d, input logic [2:0] r);
    clear = c; load = l; wr_addr = a; push = p; din = d; rd_sel = r;
    @(posedge clk);
    model_step();
    #1;
    clear = 1'b0; load = 1'b0; push = 1'b0;
  endtask

  task automatic peek(input string name, input logic [2:0] r, input logic [15:0] exp);
    rd_sel = r;
    #1;
    chk(name, {16'h0, dout}, {16'h0, exp});
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; chk_en = 1'b0;
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; push = 1'b0;
    wr_addr = 3'd0; din = 16'h0; rd_sel = 3'd0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) peek("reset_out", 3'(k), 16'h0);
    chk("reset_wptr", {29'h0, wptr}, 32'd0);
    chk("reset_count", {28'h0, count}, 32'd0);
    chk("reset_full", {31'h0, full}, 32'd0);

    for (int k = 0; k < 8; k++) apply(1'b0, 1'b1, 3'(k), 1'b0, 16'h1000 + 16'(k), 3'd0);
    for (int k = 0; k < 8; k++) peek("direct", 3'(k), 16'h1000 + 16'(k));
    chk("direct_count", {28'h0, count}, 32'd0);

    for (int k = 0; k < 9; k++) begin
      apply(1'b0, 1'b0, 3'd0, 1'b1, 16'hA0 + 16'(k), 3'd0);
      if (k == 7) begin
        chk("fill_count", {28'h0, count}, 32'd8);
        chk("fill_full", {31'h0, full}, 32'd1);
      end
    end
    chk("wrap_wptr", {29'h0, wptr}, 32'd1);
    peek("wrap_reg0", 3'd0, 16'hA8);
    peek("wrap_reg1", 3'd1, 16'hA1);

    apply(1'b0, 1'b1, 3'd5, 1'b1, 16'hBEEF, 3'd5);
    peek("prio_reg5", 3'd5, 16'hBEEF);
    chk("prio_wptr", {29'h0, wptr}, 32'd1);
    chk("prio_count", {28'h0, count}, 32'd8);
    apply(1'b1, 1'b1, 3'd2, 1'b0, 16'h1234, 3'd2);
    peek("clear_reg2", 3'd2, 16'h0);
    peek("clear_reg5", 3'd5, 16'h0);
    chk("clear_count", {28'h0, count}, 32'd0);
    chk("clear_full", {31'h0, full}, 32'd0);

    apply(1'b0, 1'b1, 3'd3, 1'b0, 16'h1111, 3'd3);
    load = 1'b1; wr_addr = 3'd3; din = 16'h5A5A; rd_sel = 3'd3;
    #1;
`ifdef REG_BANK8_BYPASS_EN
    chk("bypass_same", {16'h0, dout}, 32'h5A5A);
`else
    chk("bypass_same", {16'h0, dout}, 32'h1111);
`endif
    @(posedge clk);
    model_step();
    #1;
    load = 1'b0;
    peek("bypass_after", 3'd3, 16'h5A5A);

    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), 16'($urandom), 3'($urandom_range(0, 7)));
    end

    for (int k = 0; k < 5; k++) apply(1'b0, 1'b0, 3'd0, 1'b1, 16'hC000 + 16'(k), 3'd0);
    push = 1'b1; din = 16'hDEAD; rd_sel = 3'(pushes % 8);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_out", {16'h0, dout}, 32'd0);
    chk("async_wptr", {29'h0, wptr}, 32'd0);
    chk("async_count", {28'h0, count}, 32'd0);
    @(posedge clk);
    model_step();
    #1;
    push = 1'b0;
    rst_n = 1'b1;
    chk("async_held_count", {28'h0, count}, 32'd0);
    for (int k = 0; k < 8; k++) peek("async_nowrite", 3'(k), 16'h0);

    for (int n = 0; n < 200; n++) begin
      apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 2), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 7), 16'($urandom), 3'($urandom_range(0, 7)));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
